// File: rtl/free_list_pkg.sv
// Shared definitions for the physical-register free list and the branch stack
// that checkpoints its head pointer.
package free_list_pkg;

  localparam int unsigned NUM_PHYS_REG = 64;
  localparam int unsigned NUM_ARCH_REG = 32;
  localparam int unsigned FL_SIZE      = NUM_PHYS_REG - NUM_ARCH_REG;

  // Tag index width and pointer width (index plus one wrap bit)
  localparam int unsigned TAG_W = $clog2(NUM_PHYS_REG);
  localparam int unsigned PTR_W = $clog2(FL_SIZE) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  // Physical register tag: {ready, index}
  typedef logic [TAG_W:0] phys_reg_t;

  // Head/tail pointer: MSB is the wrap bit
  typedef logic [PTR_W-1:0] fl_ptr_t;

  // "No destination" tag; never equal to a stored tag since stored tags have ready = 0
  localparam phys_reg_t DUMMY_REG = '1;

  // FL_SIZE is a power of two, so a plain increment rolls the index and toggles the wrap bit
  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    return p + fl_ptr_t'(1);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename-side request/response bundle of the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic      enable;
  logic      dispatch_en;
  logic      retire_en;
  phys_reg_t T_old_in;
  logic      recover_en;
  fl_ptr_t   recover_head;
  phys_reg_t free_reg_out;
  logic      free_valid;
  fl_ptr_t   head_out;
  fl_ptr_t   free_cnt;
  logic      fl_error;

  // Rename / retire / recovery logic driving the list
  modport master (
    output enable, dispatch_en, retire_en, T_old_in, recover_en, recover_head,
    input  free_reg_out, free_valid, head_out, free_cnt, fl_error
  );

  // The free list itself
  modport slave (
    input  enable, dispatch_en, retire_en, T_old_in, recover_en, recover_head,
    output free_reg_out, free_valid, head_out, free_cnt, fl_error
  );

endinterface

// File: rtl/free_list.sv
// R10K physical-register free list: circular FIFO of free tags with wrap-bit
// head/tail pointers. Supplies a tag at dispatch, reclaims old tags at retire,
// and restores the head from a branch checkpoint on mispredict.
module free_list
  import free_list_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  free_list_if.slave fl
);

  phys_reg_t r_entries [FL_SIZE];
  fl_ptr_t   r_head;
  fl_ptr_t   r_tail;
  logic      r_fl_error;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_dispatch;
  logic             w_recover;
  logic             w_retire_req;
  logic             w_retire;
  phys_reg_t        w_retire_tag;
  fl_ptr_t          w_head_nxt;
  fl_ptr_t          w_tail_nxt;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[PTR_W-1] != r_tail[PTR_W-1]);

  assign w_recover    = fl.enable && fl.recover_en;
  assign w_dispatch   = fl.enable && fl.dispatch_en && !w_empty;
  assign w_retire_req = fl.enable && fl.retire_en && (fl.T_old_in != DUMMY_REG);
  // Retire into a full list is dropped (and flagged below)
  assign w_retire     = w_retire_req && !w_full;
  // Freed tags go back with the ready bit cleared
  assign w_retire_tag = {1'b0, fl.T_old_in[TAG_W-1:0]};

  // Next head: recovery wins over a same-cycle dispatch
  always_comb begin
    w_head_nxt = r_head;
    if (w_recover) begin
      w_head_nxt = fl.recover_head;
    end else if (w_dispatch) begin
      w_head_nxt = ptr_inc(r_head);
    end
  end

  // Next tail: retire is independent of recovery
  always_comb begin
    w_tail_nxt = r_tail;
    if (w_retire) begin
      w_tail_nxt = ptr_inc(r_tail);
    end
  end

  // State update; reset refills the list with the unmapped tags NUM_ARCH_REG..
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FL_SIZE; i++) begin
        r_entries[i] <= phys_reg_t'(NUM_ARCH_REG + i);
      end
      r_head     <= '0;
      r_tail     <= fl_ptr_t'(FL_SIZE);
      r_fl_error <= 1'b0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      if (w_retire) begin
        r_entries[w_tail_idx] <= w_retire_tag;
      end
      if (w_retire_req && w_full) begin
        r_fl_error <= 1'b1;
      end
    end
  end

  // Outputs depend on registered state only; no same-cycle retire bypass
  assign fl.free_reg_out = w_empty ? DUMMY_REG : r_entries[w_head_idx];
  assign fl.free_valid   = !w_empty;
  assign fl.head_out     = r_head;
  assign fl.free_cnt     = r_tail - r_head;
  assign fl.fl_error     = r_fl_error;

endmodule
